// File: rtl/avalon_gpio_debounce_if.sv
// Avalon-MM slave bus bundle for the debounced GPIO peripheral (32-bit data, 3-bit word address).
// Handshake: read/write are single-cycle strobes with no waitrequest, so every access completes
// in the cycle it is presented; readdata is valid exactly one cycle after a read strobe.
interface avalon_gpio_debounce_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_gpio_debounce.sv
// Avalon-MM GPIO: per-channel synchroniser + debouncer, output data/enable registers,
// enable-gated rise/fall edge capture with write-1-to-clear, and a registered level IRQ.
module avalon_gpio_debounce #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  avalon_gpio_debounce_if.slave  bus,
  output logic                   irq,
  input  logic [WIDTH-1:0]       pad_in,
  output logic [WIDTH-1:0]       pad_out,
  output logic [WIDTH-1:0]       pad_oe
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [2:0] A_DATA_IN  = 3'd0;
  localparam logic [2:0] A_DATA_OUT = 3'd1;
  localparam logic [2:0] A_DIR      = 3'd2;
  localparam logic [2:0] A_IRQ_MASK = 3'd3;
  localparam logic [2:0] A_EDGE_CAP = 3'd4;
  localparam logic [2:0] A_RISE_EN  = 3'd5;
  localparam logic [2:0] A_FALL_EN  = 3'd6;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_take;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_be_mask;
  logic [31:0]      w_wmasked;
  logic [31:0]      w_rd_word;
  logic [31:0]      r_readdata;
  logic             r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // w_take marks channels whose synchronised level has been held long enough to be accepted.
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign w_take = '1;
    end else begin : g_debounce
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic          w_diff;
        assign w_diff    = w_sync[i] ^ r_stable[i];
        assign w_take[i] = w_diff && (r_cnt == LAST);
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)                      r_cnt <= '0;
          else if (!w_diff || r_cnt == LAST) r_cnt <= '0;
          else                               r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable   <= '0;
      r_stable_d <= '0;
    end else begin
      r_stable   <= (w_take & w_sync) | (~w_take & r_stable);
      r_stable_d <= r_stable;
    end
  end

  assign w_set = (r_stable & ~r_stable_d & r_rise_en) | (~r_stable & r_stable_d & r_fall_en);

  assign w_be_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                      {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};
  assign w_wmasked = bus.writedata & w_be_mask;
  assign w_clr     = (bus.write && bus.address == A_EDGE_CAP) ? w_wmasked[WIDTH-1:0] : '0;

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                   input logic [31:0]      wd_m,
                                                   input logic [31:0]      mask);
    logic [31:0] m32;
    m32 = (32'(old_v) & ~mask) | wd_m;
    return m32[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
      r_dir      <= '0;
      r_irq_mask <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
    end else if (bus.write) begin
      case (bus.address)
        A_DATA_OUT: r_data_out <= lane_merge(r_data_out, w_wmasked, w_be_mask);
        A_DIR:      r_dir      <= lane_merge(r_dir,      w_wmasked, w_be_mask);
        A_IRQ_MASK: r_irq_mask <= lane_merge(r_irq_mask, w_wmasked, w_be_mask);
        A_RISE_EN:  r_rise_en  <= lane_merge(r_rise_en,  w_wmasked, w_be_mask);
        A_FALL_EN:  r_fall_en  <= lane_merge(r_fall_en,  w_wmasked, w_be_mask);
        default: ;
      endcase
    end
  end

  // A new capture takes priority over a simultaneous write-1-to-clear on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
      r_irq      <= |(r_edge_cap & r_irq_mask);
    end
  end

  always_comb begin
    w_rd_word = '0;
    case (bus.address)
      A_DATA_IN:  w_rd_word = 32'(r_stable);
      A_DATA_OUT: w_rd_word = 32'(r_data_out);
      A_DIR:      w_rd_word = 32'(r_dir);
      A_IRQ_MASK: w_rd_word = 32'(r_irq_mask);
      A_EDGE_CAP: w_rd_word = 32'(r_edge_cap);
      A_RISE_EN:  w_rd_word = 32'(r_rise_en);
      A_FALL_EN:  w_rd_word = 32'(r_fall_en);
      default:    w_rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_readdata <= '0;
    else if (bus.read) r_readdata <= w_rd_word;
    else               r_readdata <= '0;
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;
  assign pad_out      = r_data_out;
  assign pad_oe       = r_dir;

endmodule

// File: tb/tb_avalon_gpio_debounce.sv
// Directed bench for avalon_gpio_debounce: a debounced 32-channel instance and a 10-channel
// bypass instance, with read expectations queued at issue and checked when readdata returns.
module tb_avalon_gpio_debounce;

  logic        clk;
  logic        reset_n;
  logic        irq1, irq2;
  logic [31:0] pad_in1, pad_out1, pad_oe1;
  logic [9:0]  pad_in2, pad_out2, pad_oe2;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_tests;
  int          n_fail;

  avalon_gpio_debounce_if bus1 ();
  avalon_gpio_debounce_if bus2 ();

  avalon_gpio_debounce #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .irq(irq1),
    .pad_in(pad_in1), .pad_out(pad_out1), .pad_oe(pad_oe1)
  );

  avalon_gpio_debounce #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .irq(irq2),
    .pad_in(pad_in2), .pad_out(pad_out2), .pad_oe(pad_oe2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: inputs change just after the falling edge, DUT samples on the next rising edge
  task automatic bus_cycle(input int inst, input logic rd, input logic wr, input logic [2:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
    if (inst == 0) begin
      bus1.read = rd; bus1.write = wr; bus1.address = addr; bus1.writedata = wd; bus1.byteenable = be;
    end else begin
      bus2.read = rd; bus2.write = wr; bus2.address = addr; bus2.writedata = wd; bus2.byteenable = be;
    end
    @(negedge clk);
    bus1.read = 1'b0; bus1.write = 1'b0;
    bus2.read = 1'b0; bus2.write = 1'b0;
  endtask

  task automatic wr(input int inst, input logic [2:0] addr, input logic [31:0] wd, input logic [3:0] be);
    bus_cycle(inst, 1'b0, 1'b1, addr, wd, be);
  endtask

  // scoreboard: expectation queued when the read is issued, popped when readdata is valid
  task automatic rd_chk(input int inst, input logic [2:0] addr, input logic [31:0] exp,
                        input string tag, input logic also_wr = 1'b0, input logic [31:0] wd = '0);
    logic [31:0] obs;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus_cycle(inst, 1'b1, also_wr, addr, wd, 4'hF);
    obs = (inst == 0) ? bus1.readdata : bus2.readdata;
    chk(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    pad_in1 = '0;
    pad_in2 = '0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0; bus1.writedata = '0; bus1.byteenable = '0;
    bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = '0; bus2.writedata = '0; bus2.byteenable = '0;

    #1;
    chk("por_pad_out", pad_out1, 32'h0);
    chk("por_pad_oe", pad_oe1, 32'h0);
    chk("por_irq", 32'(irq1), 32'h0);
    chk("por_readdata", bus1.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // enable rise capture and IRQ on channel 0 before the debounce tests
    wr(0, 3'd5, 32'h1, 4'hF);
    wr(0, 3'd3, 32'h1, 4'hF);
    rd_chk(0, 3'd5, 32'h1, "rise_en_rb");
    rd_chk(0, 3'd3, 32'h1, "irq_mask_rb");

    // 3-cycle glitch must be rejected
    pad_in1 = 32'h1;
    for (int k = 0; k < 3; k++) rd_chk(0, 3'd0, 32'h0, "glitch_hi");
    pad_in1 = 32'h0;
    for (int k = 0; k < 8; k++) rd_chk(0, 3'd0, 32'h0, "glitch_after");
    chk("glitch_edge_irq", 32'(irq1), 32'h0);

    // held level: accepted at the 6th edge, so the read sampled on the 7th edge sees it
    pad_in1 = 32'h1;
    for (int k = 1; k <= 7; k++) rd_chk(0, 3'd0, (k >= 7) ? 32'h1 : 32'h0, $sformatf("latency_e%0d", k));
    chk("irq_before_capture", 32'(irq1), 32'h0);
    rd_chk(0, 3'd4, 32'h1, "edge_cap_rise");
    chk("irq_after_capture", 32'(irq1), 32'h1);
    wr(0, 3'd4, 32'h1, 4'hF);
    chk("irq_hold_on_w1c", 32'(irq1), 32'h1);
    @(negedge clk);
    chk("irq_clear_after_w1c", 32'(irq1), 32'h0);
    rd_chk(0, 3'd4, 32'h0, "edge_cap_cleared");

    // W1C lands in the same cycle as a new fall capture: the capture wins
    wr(0, 3'd6, 32'h1, 4'hF);
    pad_in1 = 32'h0;
    repeat (6) @(negedge clk);
    wr(0, 3'd4, 32'h1, 4'hF);
    @(negedge clk);
    chk("race_irq", 32'(irq1), 32'h1);
    rd_chk(0, 3'd4, 32'h1, "race_edge_cap");
    chk("race_irq_stays", 32'(irq1), 32'h1);
    rd_chk(0, 3'd0, 32'h0, "data_in_fell");

    // byte-lane writes and pad drive
    wr(0, 3'd1, 32'hAABBCCDD, 4'b0101);
    chk("pad_out_lanes", pad_out1, 32'h00BB00DD);
    rd_chk(0, 3'd1, 32'h00BB00DD, "data_out_lanes");
    wr(0, 3'd2, 32'h0000FFFF, 4'hF);
    chk("pad_oe_ffff", pad_oe1, 32'h0000FFFF);
    rd_chk(0, 3'd1, 32'h00BB00DD, "rd_wr_same_cycle", 1'b1, 32'h12345678);
    rd_chk(0, 3'd1, 32'h12345678, "rd_after_rw");
    wr(0, 3'd7, 32'hFFFFFFFF, 4'hF);
    rd_chk(0, 3'd7, 32'h0, "addr7_reads_0");

    // asynchronous reset in the middle of a debounce with outputs driven and irq high
    wr(0, 3'd2, 32'h000000FF, 4'hF);
    chk("pre_reset_pad_oe", pad_oe1, 32'h000000FF);
    chk("pre_reset_irq", 32'(irq1), 32'h1);
    pad_in1 = 32'h1;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    pad_in1 = 32'h0;
    #1;
    chk("rst_pad_oe", pad_oe1, 32'h0);
    chk("rst_pad_out", pad_out1, 32'h0);
    chk("rst_irq", 32'(irq1), 32'h0);
    chk("rst_readdata", bus1.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd_chk(0, 3'(a), 32'h0, $sformatf("rst_reg%0d", a));
    chk("rst_irq_after", 32'(irq1), 32'h0);

    // 10-channel instance with debounce bypassed
    chk("w10_pad_out", 32'(pad_out2), 32'h0);
    wr(1, 3'd2, 32'hFFFFFFFF, 4'hF);
    chk("w10_pad_oe", 32'(pad_oe2), 32'h000003FF);
    rd_chk(1, 3'd2, 32'h000003FF, "w10_dir");
    rd_chk(1, 3'd7, 32'h0, "w10_addr7");
    pad_in2 = 10'h201;
    for (int k = 1; k <= 4; k++) rd_chk(1, 3'd0, (k >= 4) ? 32'h201 : 32'h0, $sformatf("bypass_e%0d", k));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
